// File: rtl/debounce_pkg.sv
// Shared state encoding and width helpers for the debounce bank.
package debounce_pkg;

   typedef logic [1:0] state_t;

   // Bit 1 of the encoding is the debounced level.
   localparam state_t STABLE_LO = 2'b00;
   localparam state_t WAIT_HI   = 2'b01;
   localparam state_t STABLE_HI = 2'b11;
   localparam state_t WAIT_LO   = 2'b10;

   // clog2 clamped to a minimum width of one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input inversion, 2-flop synchroniser, stability FSM, edge pulses.
//
// state     | meaning
// STABLE_LO | accepted level 0, watching for s=1
// WAIT_HI   | s went high, counting ticks before accepting 1
// STABLE_HI | accepted level 1, watching for s=0
// WAIT_LO   | s went low, counting ticks before accepting 0
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = 10,
   parameter bit          ACTIVE_LOW   = 1'b0
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_tick,
   input  logic i_switch,
   output logic o_signal,
   output logic o_rise,
   output logic o_fall
);

   localparam int unsigned   CW       = width_of(STABLE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          raw;
   logic          sync_q;
   logic          s_q;
   state_t        state_q;
   state_t        state_nxt;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_nxt;
   logic          rise_nxt;
   logic          fall_nxt;
   logic          rise_q;
   logic          fall_q;

   assign raw = i_switch ^ ACTIVE_LOW;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         sync_q <= 1'b0;
         s_q    <= 1'b0;
      end else begin
         sync_q <= raw;
         s_q    <= sync_q;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         rise_q  <= rise_nxt;
         fall_q  <= fall_nxt;
      end
   end

   // A level mismatch on s always wins over an accepting tick.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         STABLE_LO: begin
            if (s_q) begin
               state_nxt = WAIT_HI;
               cnt_nxt   = '0;
            end
         end
         WAIT_HI: begin
            if (!s_q) begin
               state_nxt = STABLE_LO;
            end else if (i_tick) begin
               if (cnt_q == CNT_LAST) state_nxt = STABLE_HI;
               else                   cnt_nxt   = cnt_q + CW'(1);
            end
         end
         STABLE_HI: begin
            if (!s_q) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = '0;
            end
         end
         WAIT_LO: begin
            if (s_q) begin
               state_nxt = STABLE_HI;
            end else if (i_tick) begin
               if (cnt_q == CNT_LAST) state_nxt = STABLE_LO;
               else                   cnt_nxt   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      o_signal = (state_q == STABLE_HI) || (state_q == WAIT_LO);
      rise_nxt = (state_q == WAIT_HI) && (state_nxt == STABLE_HI);
      fall_nxt = (state_q == WAIT_LO) && (state_nxt == STABLE_LO);
   end

   assign o_rise = rise_q;
   assign o_fall = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer sharing one tick prescaler across all channels.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int unsigned      NB_CH        = 6,
   parameter int unsigned      TICK_DIV     = 100000,
   parameter int unsigned      STABLE_TICKS = 10,
   parameter logic [NB_CH-1:0] ACTIVE_LOW   = {NB_CH{1'b0}}
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [NB_CH-1:0] i_switch,
   output logic [NB_CH-1:0] o_signal,
   output logic [NB_CH-1:0] o_rise,
   output logic [NB_CH-1:0] o_fall,
   output logic             o_tick
);

   localparam int unsigned   PW       = width_of(TICK_DIV);
   localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] div_q;
   logic [PW-1:0] div_nxt;
   logic          tick_q;

   always_comb begin
      div_nxt = (div_q == DIV_LAST) ? '0 : div_q + PW'(1);
   end

   // tick_q tracks div_q == DIV_LAST but stays low while in reset.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_nxt;
         tick_q <= (div_nxt == DIV_LAST);
      end
   end

   assign o_tick = tick_q;

   for (genvar i = 0; i < NB_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .ACTIVE_LOW   (ACTIVE_LOW[i])
      ) u_ch (
         .i_clock  (i_clock),
         .i_reset  (i_reset),
         .i_tick   (tick_q),
         .i_switch (i_switch[i]),
         .o_signal (o_signal[i]),
         .o_rise   (o_rise[i]),
         .o_fall   (o_fall[i])
      );
   end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-switch debouncer used on the board-level top.
- Debounces NB_CH asynchronous switch/button inputs with a shared tick prescaler.
- Per channel it provides:
  - a 2-flop synchroniser;
  - optional active-low inversion;
  - a stable debounced level;
  - single-cycle rise and fall pulses.
- Feeds board controls (step, run, mode select) into the MIPS debug/top logic.

Parameters:
- NB_CH, 6, number of independent input channels (>=1).
- TICK_DIV, 100000, clock cycles per debounce tick (>=1); prescaler width is clog2(TICK_DIV), minimum 1.
- STABLE_TICKS, 10, consecutive ticks an input must hold its new level before it is accepted (>=1); counter width is clog2(STABLE_TICKS+1).
- ACTIVE_LOW, {NB_CH{1'b0}}, per-channel mask; a set bit inverts that channel's raw input before synchronisation.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_switch  input  NB_CH  raw, asynchronous switch inputs.
- o_signal  output  NB_CH  debounced level per channel.
- o_rise  output  NB_CH  one-cycle pulse when o_signal goes 0->1.
- o_fall  output  NB_CH  one-cycle pulse when o_signal goes 1->0.
- o_tick  output  1  prescaler tick (debug/visibility).

Behaviour:
- One clock; reset is asynchronous and active-high (i_clock, i_reset). All flops clear on reset assertion without waiting for a clock edge.
- Reset values:
  - o_signal, o_rise, o_fall, o_tick = 0.
  - Synchroniser flops = 0.
  - Prescaler = 0.
  - All channel FSMs in STABLE_LO with count 0.
- Input path: raw = i_switch XOR ACTIVE_LOW, then a 2-flop synchroniser. The second flop is "s".
- Prescaler:
  - Counts 0..TICK_DIV-1; o_tick = 1 for exactly the cycle in which the counter equals TICK_DIV-1, then it wraps to 0.
  - TICK_DIV=1 gives o_tick = 1 every cycle.
  - The tick is shared by all channels.
- Per-channel FSM, all transitions registered:
  - STABLE_LO: s=1 -> WAIT_HI, count cleared to 0.
  - WAIT_HI:
    - s=0 -> STABLE_LO (glitch rejected, no pulse, o_signal stays 0).
    - Else, on tick with count==STABLE_TICKS-1 -> STABLE_HI.
    - Else, on tick -> count+1.
  - STABLE_HI: s=0 -> WAIT_LO, count cleared to 0.
  - WAIT_LO is symmetric to WAIT_HI:
    - s=1 -> STABLE_HI.
    - On tick with count==STABLE_TICKS-1 -> STABLE_LO.
- Outputs:
  - o_signal is registered: 1 in STABLE_HI and WAIT_LO, 0 in STABLE_LO and WAIT_HI.
  - o_rise is asserted for exactly the one cycle after the WAIT_HI->STABLE_HI edge, simultaneously with o_signal first reading 1.
  - o_fall likewise on WAIT_LO->STABLE_LO.
  - o_rise and o_fall are never both high on one channel.
- Latency, TICK_DIV=1: o_signal changes exactly 3+STABLE_TICKS clock edges after the first edge that samples the new i_switch level.
- Latency, general: between 3+(STABLE_TICKS-1)*TICK_DIV+1 and 3+STABLE_TICKS*TICK_DIV edges, depending on prescaler phase.
- Boundary conditions:
  - Glitch shorter than the stability window, including a flip exactly on the accepting tick edge: the s mismatch has priority over the tick, so the change is rejected.
  - Counters never exceed STABLE_TICKS-1; no wrap.
  - Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
  - Reset mid-WAIT: the channel returns to STABLE_LO, o_signal=0, and no pulse is emitted.
  - A channel held high through reset release produces o_rise after the normal latency, because reset establishes a 0 baseline.

Decomposition:
- Package debounce_pkg:
  - FSM state encoding localparams: STABLE_LO=2'b00, WAIT_HI=2'b01, STABLE_HI=2'b11, WAIT_LO=2'b10.
  - clog2-based width helper constants.
- Sub-module debounce_channel:
  - Contains the synchroniser, FSM, counter and pulse registers.
  - Instantiated NB_CH times by a generate loop.
- The prescaler lives in debounce_bank.

Test Plan:
- Reset, then hold i_switch=0 for 50 cycles (TICK_DIV=1, STABLE_TICKS=4) -> o_signal=0; o_rise, o_fall never asserted.
- Channel 0: 0->1 step held, TICK_DIV=1, STABLE_TICKS=4 -> o_signal[0] rises exactly 7 edges after sampling, with o_rise[0] high that same single cycle.
- Channel 1: 3-cycle high glitch (window 4 ticks) -> o_signal[1] stays 0, no o_rise; a 6-cycle pulse -> rise then later fall, one pulse each.
- ACTIVE_LOW=6'b000100, i_switch[2] held 0 from reset -> o_signal[2]=1 after 3+STABLE_TICKS edges plus one o_rise[2]; driving 1 then gives o_fall[2].
- TICK_DIV=5, STABLE_TICKS=3, step on channels 3 and 5 in the same cycle -> both rise in the same cycle, latency within [14,18] edges; o_tick period 5.
- Assert i_reset asynchronously while channel 4 is in WAIT_HI with count=2 -> immediate o_signal=0 and FSM in STABLE_LO; no pulse; after release the held-high input re-debounces fully.
